// File: rtl/gshare_checkpoint_controller.sv
// gshare predictor sequencer: issues predictions, checkpoints per-branch
// history in an in-order queue, drives PHT updates and GHR rollback.
module gshare_checkpoint_controller #(
    parameter int HISTORY_LEN = 8,
    parameter int DEPTH       = 4,
    parameter int TAG_W       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   predict_req,
    input  logic [15:0]            predict_pc,
    output logic                   predict_ack,
    output logic                   predict_taken,
    output logic [TAG_W-1:0]       predict_tag,
    input  logic                   resolve_valid,
    input  logic                   resolve_outcome,
    output logic                   resolve_ready,
    output logic                   mispredict,
    output logic                   flush,
    output logic [TAG_W:0]         occupancy,
    output logic [15:0]            pred_pc_bits_read,
    output logic                   pred_predict_enable,
    input  logic                   pred_prediction,
    input  logic [HISTORY_LEN-1:0] pred_history_read,
    output logic [15:0]            pred_pc_bits_write,
    output logic [HISTORY_LEN-1:0] pred_history_write,
    output logic                   pred_write_enabled,
    output logic                   pred_outcome,
    output logic                   pred_rollback_enabled
);

    typedef enum logic {
        RUN,
        ROLLBACK
    } state_t;

    localparam logic [TAG_W:0]   FULL     = (TAG_W+1)'(DEPTH);
    localparam logic [TAG_W:0]   OCC_ONE  = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

    state_t state;
    state_t state_next;

    logic [15:0]            pc_q   [DEPTH];
    logic [HISTORY_LEN-1:0] hist_q [DEPTH];
    logic                   pred_q [DEPTH];

    logic [TAG_W-1:0]       head;
    logic [TAG_W-1:0]       tail;
    logic [TAG_W:0]         occ;
    logic [HISTORY_LEN-1:0] rb_hist;

    logic [15:0]            head_pc;
    logic [HISTORY_LEN-1:0] head_hist;
    logic                   head_pred;
    logic                   res_acc;
    logic                   misp;
    logic                   accept;
    logic                   in_rollback;

    assign head_pc   = pc_q[head];
    assign head_hist = hist_q[head];
    assign head_pred = pred_q[head];

    assign in_rollback = (state == ROLLBACK);

    // Every strobe is gated by reset so nothing leaks out during reset.
    assign resolve_ready = (state == RUN) && (occ != '0);
    assign res_acc       = resolve_valid && resolve_ready && !reset;
    assign misp          = res_acc && (resolve_outcome != head_pred);
    assign accept        = (state == RUN) && predict_req && (occ != FULL)
                           && !misp && !reset;

    assign predict_ack           = accept;
    assign pred_predict_enable   = accept;
    assign predict_taken         = pred_prediction;
    assign predict_tag           = tail;
    assign pred_pc_bits_read     = predict_pc;
    assign occupancy             = occ;
    assign mispredict            = misp;
    assign pred_write_enabled    = res_acc;
    assign pred_outcome          = resolve_outcome;
    assign pred_pc_bits_write    = head_pc;
    assign pred_history_write    = in_rollback ? rb_hist : head_hist;
    assign pred_rollback_enabled = in_rollback && !reset;
    assign flush                 = in_rollback && !reset;

    always_comb begin
        state_next = state;
        unique case (state)
            RUN:      if (misp) state_next = ROLLBACK;
            ROLLBACK: state_next = RUN;
            default:  state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            head    <= '0;
            tail    <= '0;
            occ     <= '0;
            rb_hist <= '0;
        end else begin
            state <= state_next;
            if (misp) begin
                // Corrected history: checkpoint shifted with the real outcome.
                rb_hist <= {head_hist[HISTORY_LEN-2:0], resolve_outcome};
                head    <= '0;
                tail    <= '0;
                occ     <= '0;
            end else begin
                if (accept) tail <= tail + TAG_ONE;
                if (res_acc) head <= head + TAG_ONE;
                unique case ({accept, res_acc})
                    2'b10:   occ <= occ + OCC_ONE;
                    2'b01:   occ <= occ - OCC_ONE;
                    default: occ <= occ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pc_q[tail]   <= predict_pc;
            hist_q[tail] <= pred_history_read;
            pred_q[tail] <= pred_prediction;
        end
    end

endmodule

// File: tb/tb_gshare_checkpoint_controller.sv
// Scoreboard bench for gshare_checkpoint_controller: directed vectors,
// expected acks/updates/rollbacks queued and popped by a negedge monitor.
module tb_gshare_checkpoint_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        predict_req;
    logic [15:0] predict_pc;
    logic        predict_ack;
    logic        predict_taken;
    logic [1:0]  predict_tag;
    logic        resolve_valid;
    logic        resolve_outcome;
    logic        resolve_ready;
    logic        mispredict;
    logic        flush;
    logic [2:0]  occupancy;
    logic [15:0] pred_pc_bits_read;
    logic        pred_predict_enable;
    logic        pred_prediction;
    logic [7:0]  pred_history_read;
    logic [15:0] pred_pc_bits_write;
    logic [7:0]  pred_history_write;
    logic        pred_write_enabled;
    logic        pred_outcome;
    logic        pred_rollback_enabled;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] tag;
        logic       taken;
    } ack_t;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  hist;
        logic        outcome;
        logic        misp;
    } wr_t;

    ack_t       ack_q[$];
    wr_t        wr_q[$];
    logic [7:0] rb_q[$];

    gshare_checkpoint_controller dut (
        .clk                   (clk),
        .reset                 (reset),
        .predict_req           (predict_req),
        .predict_pc            (predict_pc),
        .predict_ack           (predict_ack),
        .predict_taken         (predict_taken),
        .predict_tag           (predict_tag),
        .resolve_valid         (resolve_valid),
        .resolve_outcome       (resolve_outcome),
        .resolve_ready         (resolve_ready),
        .mispredict            (mispredict),
        .flush                 (flush),
        .occupancy             (occupancy),
        .pred_pc_bits_read     (pred_pc_bits_read),
        .pred_predict_enable   (pred_predict_enable),
        .pred_prediction       (pred_prediction),
        .pred_history_read     (pred_history_read),
        .pred_pc_bits_write    (pred_pc_bits_write),
        .pred_history_write    (pred_history_write),
        .pred_write_enabled    (pred_write_enabled),
        .pred_outcome          (pred_outcome),
        .pred_rollback_enabled (pred_rollback_enabled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic req, input logic [15:0] pc,
                          input logic [7:0] h, input logic p,
                          input logic rv, input logic ro);
        predict_req       = req;
        predict_pc        = pc;
        pred_history_read = h;
        pred_prediction   = p;
        resolve_valid     = rv;
        resolve_outcome   = ro;
    endtask

    task automatic exp_ack(input logic [1:0] tag, input logic taken);
        ack_t a;
        a.tag   = tag;
        a.taken = taken;
        ack_q.push_back(a);
    endtask

    task automatic exp_wr(input logic [15:0] pc, input logic [7:0] h,
                          input logic o, input logic m);
        wr_t w;
        w.pc      = pc;
        w.hist    = h;
        w.outcome = o;
        w.misp    = m;
        wr_q.push_back(w);
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented ack/update/rollback must match the next
    // queued expectation.
    always @(negedge clk) begin
        if (predict_ack) begin
            if (ack_q.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                ack_t a;
                a = ack_q.pop_front();
                chk("ack_tag", 32'(predict_tag), 32'(a.tag));
                chk("ack_taken", 32'(predict_taken), 32'(a.taken));
            end
        end
        if (pred_write_enabled) begin
            if (wr_q.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                wr_t w;
                w = wr_q.pop_front();
                chk("wr_pc", 32'(pred_pc_bits_write), 32'(w.pc));
                chk("wr_hist", 32'(pred_history_write), 32'(w.hist));
                chk("wr_outcome", 32'(pred_outcome), 32'(w.outcome));
                chk("wr_mispredict", 32'(mispredict), 32'(w.misp));
            end
        end
        if (pred_rollback_enabled) begin
            if (rb_q.size() == 0) begin
                chk("unexpected_rollback", 32'd1, 32'd0);
            end else begin
                logic [7:0] r;
                r = rb_q.pop_front();
                chk("rb_hist", 32'(pred_history_write), 32'(r));
                chk("rb_flush", 32'(flush), 32'd1);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        set_in(1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
        repeat (2) begin
            half();
            chk("rst_ack", 32'(predict_ack), 32'd0);
            chk("rst_pe", 32'(pred_predict_enable), 32'd0);
            chk("rst_we", 32'(pred_write_enabled), 32'd0);
            chk("rst_rb", 32'(pred_rollback_enabled), 32'd0);
            chk("rst_misp", 32'(mispredict), 32'd0);
            chk("rst_flush", 32'(flush), 32'd0);
        end
        reset = 1'b0;
        set_in(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        half();
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_ready", 32'(resolve_ready), 32'd0);
        chk("rst_flush2", 32'(flush), 32'd0);
        fin();

        // Fill the queue.
        for (int k = 0; k < 4; k++) begin
            logic [15:0] pc;
            logic        p;
            pc = 16'h0010 + 16'(4 * k);
            p  = (k % 2) == 1;
            set_in(1'b1, pc, 8'h00, p, 1'b0, 1'b0);
            exp_ack(2'(k), p);
            half();
            chk("fill_pe", 32'(pred_predict_enable), 32'd1);
            chk("fill_pc_read", 32'(pred_pc_bits_read), 32'(pc));
            chk("fill_occ", 32'(occupancy), 32'(k));
            fin();
        end
        set_in(1'b1, 16'h0020, 8'h00, 1'b0, 1'b0, 1'b0);
        half();
        chk("full_ack", 32'(predict_ack), 32'd0);
        chk("full_pe", 32'(pred_predict_enable), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd4);
        fin();

        // Correct resolves drain the queue.
        for (int k = 0; k < 4; k++) begin
            logic o;
            o = (k % 2) == 1;
            set_in(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, o);
            exp_wr(16'h0010 + 16'(4 * k), 8'h00, o, 1'b0);
            half();
            chk("drain_occ", 32'(occupancy), 32'(4 - k));
            chk("drain_ready", 32'(resolve_ready), 32'd1);
            fin();
        end

        // Mispredict and rollback.
        set_in(1'b1, 16'h0020, 8'h5A, 1'b0, 1'b0, 1'b0);
        exp_ack(2'd0, 1'b0);
        half();
        chk("empty_occ", 32'(occupancy), 32'd0);
        chk("empty_ready", 32'(resolve_ready), 32'd0);
        fin();
        set_in(1'b1, 16'h0024, 8'h5A, 1'b0, 1'b1, 1'b1);
        exp_wr(16'h0020, 8'h5A, 1'b1, 1'b1);
        half();
        chk("misp_ack", 32'(predict_ack), 32'd0);
        chk("misp", 32'(mispredict), 32'd1);
        chk("misp_occ", 32'(occupancy), 32'd1);
        fin();
        set_in(1'b1, 16'h0024, 8'h00, 1'b0, 1'b0, 1'b0);
        rb_q.push_back(8'hB5);
        half();
        chk("rb_en", 32'(pred_rollback_enabled), 32'd1);
        chk("rb_ack", 32'(predict_ack), 32'd0);
        chk("rb_pe", 32'(pred_predict_enable), 32'd0);
        chk("rb_occ", 32'(occupancy), 32'd0);
        chk("rb_ready", 32'(resolve_ready), 32'd0);
        fin();
        set_in(1'b1, 16'h0030, 8'hB5, 1'b1, 1'b0, 1'b0);
        exp_ack(2'd0, 1'b1);
        half();
        chk("post_rb_flush", 32'(flush), 32'd0);
        fin();

        // Build occupancy 2 with tail 3, then predict+resolve together.
        set_in(1'b1, 16'h0034, 8'h6B, 1'b0, 1'b0, 1'b0);
        exp_ack(2'd1, 1'b0);
        half();
        fin();
        set_in(1'b1, 16'h0038, 8'hD6, 1'b1, 1'b0, 1'b0);
        exp_ack(2'd2, 1'b1);
        half();
        fin();
        set_in(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1);
        exp_wr(16'h0030, 8'hB5, 1'b1, 1'b0);
        half();
        chk("pre_sim_occ", 32'(occupancy), 32'd3);
        fin();
        set_in(1'b1, 16'h003C, 8'h3C, 1'b0, 1'b1, 1'b0);
        exp_ack(2'd3, 1'b0);
        exp_wr(16'h0034, 8'h6B, 1'b0, 1'b0);
        half();
        chk("sim_occ", 32'(occupancy), 32'd2);
        fin();
        set_in(1'b1, 16'h0040, 8'h81, 1'b1, 1'b0, 1'b0);
        exp_ack(2'd0, 1'b1);
        half();
        chk("post_sim_occ", 32'(occupancy), 32'd2);
        fin();
        set_in(1'b1, 16'h0044, 8'h03, 1'b0, 1'b0, 1'b0);
        exp_ack(2'd1, 1'b0);
        half();
        chk("wrap_occ", 32'(occupancy), 32'd3);
        fin();

        // Full: resolve pops but predict is still refused.
        set_in(1'b1, 16'h0048, 8'h00, 1'b0, 1'b1, 1'b1);
        exp_wr(16'h0038, 8'hD6, 1'b1, 1'b0);
        half();
        chk("full2_occ", 32'(occupancy), 32'd4);
        chk("full2_ack", 32'(predict_ack), 32'd0);
        fin();

        // Mispredict, then reset during the rollback cycle.
        set_in(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b1);
        exp_wr(16'h003C, 8'h3C, 1'b1, 1'b1);
        half();
        chk("misp2_occ", 32'(occupancy), 32'd3);
        chk("misp2", 32'(mispredict), 32'd1);
        fin();
        reset = 1'b1;
        set_in(1'b1, 16'h0050, 8'h00, 1'b0, 1'b1, 1'b0);
        half();
        chk("rstrb_rb", 32'(pred_rollback_enabled), 32'd0);
        chk("rstrb_flush", 32'(flush), 32'd0);
        chk("rstrb_ack", 32'(predict_ack), 32'd0);
        chk("rstrb_misp", 32'(mispredict), 32'd0);
        fin();
        reset = 1'b0;
        set_in(1'b0, 16'h0000, 8'h00, 1'b0, 1'b1, 1'b0);
        half();
        chk("after_rst_rb", 32'(pred_rollback_enabled), 32'd0);
        chk("after_rst_flush", 32'(flush), 32'd0);
        chk("after_rst_occ", 32'(occupancy), 32'd0);
        chk("after_rst_ready", 32'(resolve_ready), 32'd0);
        fin();
        set_in(1'b1, 16'h0050, 8'h11, 1'b1, 1'b0, 1'b0);
        exp_ack(2'd0, 1'b1);
        half();
        fin();
        set_in(1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 1'b0);
        half();
        chk("final_occ", 32'(occupancy), 32'd1);
        chk("ack_q_drained", 32'(ack_q.size()), 32'd0);
        chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
        chk("rb_q_drained", 32'(rb_q.size()), 32'd0);
        fin();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
